control_mouse: RTL and testbench

- Receive-only PS/2 mouse interface. It samples the mouse clock/data lines, assembles standard 3-byte movement packets (33 bits) and decodes them into a left-click flag, four direction flags and 8-bit X/Y magnitudes.
- Sits between the board PS/2 pins and the cursor/game logic. It never drives the PS/2 lines.

---
 rtl/control_mouse_pkg.sv | 35 +++
 rtl/control_mouse_edge_sync.sv | 37 +++
 rtl/control_mouse.sv | 125 ++++++++++++
 tb/tb_control_mouse.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/control_mouse_pkg.sv
// Shared PS/2 mouse packet constants and the magnitude decode helper.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package control_mouse_pkg;

    // Each PS/2 byte is framed as start, 8 data bits LSB first, odd parity, stop.
    localparam int PS2_FRAME_BITS = 11;
    localparam int PACKET_BITS    = 33;

    // Bit positions inside the status byte.
    localparam int BTN_L   = 0;
    localparam int ALWAYS1 = 3;
    localparam int XSIGN   = 4;
    localparam int YSIGN   = 5;
    localparam int XOVF    = 6;
    localparam int YOVF    = 7;

    // |{sgn, mag_byte}| as 9-bit two's complement. The result is clamped to 8 bits:
    // -256 (sign set, byte zero) and any overflowed axis report 255.
    function automatic logic [7:0] ps2_mag(input logic sgn, input logic ovf,
                                           input logic [7:0] mag_byte);
        logic [7:0] res;
        if (ovf) begin
            res = 8'hFF;
        end else if (!sgn) begin
            res = mag_byte;
        end else if (mag_byte == 8'h00) begin
            res = 8'hFF;
        end else begin
            res = ~mag_byte + 8'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/control_mouse_edge_sync.sv
// Synchronizes the PS/2 clock and data pins and flags falling edges of the clock.
// Latency: SYNC_STAGES+1 Clk from a pin edge to fall; dat lines up with fall.
// Backpressure: none; fall is a single-cycle strobe.
// Ports: Clk/Rst system clock and sync reset; ps2_clk/ps2_dat raw pins;
//        fall one-cycle falling-edge strobe; dat synchronized data bit.
module ps2_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Rst,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic fall,
    output logic dat
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;

    // Reset to the idle-high line level so leaving reset never fakes an edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign dat  = dat_sync[SYNC_STAGES-1];

endmodule

// File: rtl/control_mouse.sv
// Receive-only PS/2 mouse: assembles 33-bit movement packets and decodes click/direction/magnitude.
// Latency: outputs update 1 Clk after the synchronized 33rd falling edge (c clears on that edge).
// Backpressure: none; the mouse cannot be stalled, outputs simply hold until the next valid packet.
// Ports: Clk, Rst (sync active-high); M_CLK, M_Dat PS/2 pins (M_Dat only read, driven z);
//        Click, Izquierda, Derecha, Arriba, Abajo, MagX, MagY decoded state; c live bit count.
module control_mouse
    import control_mouse_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        M_CLK,
    inout  wire         M_Dat,
    output logic        Click,
    output logic        Izquierda,
    output logic        Derecha,
    output logic        Arriba,
    output logic        Abajo,
    output logic [7:0]  MagX,
    output logic [7:0]  MagY,
    output logic [31:0] c
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int F1 = PS2_FRAME_BITS;
    localparam int F2 = 2 * PS2_FRAME_BITS;

    assign M_Dat = 1'bz;

    logic                   fall;
    logic                   dat;
    logic [PACKET_BITS-1:0] sr;
    logic [5:0]             cnt;
    logic [TW-1:0]          timer;
    logic                   pkt_done;

    ps2_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .Clk     (Clk),
        .Rst     (Rst),
        .ps2_clk (M_CLK),
        .ps2_dat (M_Dat),
        .fall    (fall),
        .dat     (dat)
    );

    // Bits shift in from the top, so after 33 edges the first bit sits at sr[0]
    // and byte k occupies sr[11k +: 11] as {stop, parity, data[7:0], start}.
    logic [7:0] st;
    logic [7:0] xb;
    logic [7:0] yb;
    logic       pkt_ok;

    assign st = sr[8:1];
    assign xb = sr[F1+8:F1+1];
    assign yb = sr[F2+8:F2+1];

    always_comb begin
        pkt_ok = 1'b1;
        if (sr[0] || sr[F1] || sr[F2])                  pkt_ok = 1'b0;
        if (!sr[10] || !sr[F1+10] || !sr[F2+10])        pkt_ok = 1'b0;
        if (!(^sr[9:1]) || !(^sr[F1+9:F1+1]) || !(^sr[F2+9:F2+1])) pkt_ok = 1'b0;
        if (!st[ALWAYS1])                               pkt_ok = 1'b0;
    end

    // Negative 9-bit values are never zero; an overflowed axis counts as moving.
    logic x_nz;
    logic y_nz;
    assign x_nz = (xb != 8'h00) || st[XOVF];
    assign y_nz = (yb != 8'h00) || st[YOVF];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sr        <= '0;
            cnt       <= '0;
            timer     <= '0;
            pkt_done  <= 1'b0;
            Click     <= 1'b0;
            Izquierda <= 1'b0;
            Derecha   <= 1'b0;
            Arriba    <= 1'b0;
            Abajo     <= 1'b0;
            MagX      <= '0;
            MagY      <= '0;
        end else begin
            pkt_done <= 1'b0;

            if (pkt_done && pkt_ok) begin
                Click     <= st[BTN_L];
                Derecha   <= !st[XSIGN] && x_nz;
                Izquierda <= st[XSIGN];
                Arriba    <= !st[YSIGN] && y_nz;
                Abajo     <= st[YSIGN];
                MagX      <= ps2_mag(st[XSIGN], st[XOVF], xb);
                MagY      <= ps2_mag(st[YSIGN], st[YOVF], yb);
            end

            // Timeout takes priority over an edge landing in the same cycle.
            if (cnt != '0 && timer == TW'(TIMEOUT_CYCLES - 1)) begin
                cnt   <= '0;
                sr    <= '0;
                timer <= '0;
            end else if (fall) begin
                sr    <= {dat, sr[PACKET_BITS-1:1]};
                timer <= '0;
                if (cnt == 6'(PACKET_BITS - 1)) begin
                    cnt      <= '0;
                    pkt_done <= 1'b1;
                end else begin
                    cnt <= cnt + 6'd1;
                end
            end else if (cnt != '0) begin
                timer <= timer + TW'(1);
            end else begin
                timer <= '0;
            end
        end
    end

    assign c = 32'(cnt);

endmodule

// File: tb/tb_control_mouse.sv
`timescale 1ns/1ps
module tb_control_mouse;

    localparam int TMO  = 2000;
    localparam int HALF = 8;

    typedef struct packed {
        logic       click;
        logic       iz;
        logic       de;
        logic       ar;
        logic       ab;
        logic [7:0] mx;
        logic [7:0] my;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_clk = 1'b1;
    logic        m_dat_drv = 1'b1;
    wire         m_dat;
    logic        click, iz, de, ar, ab;
    logic [7:0]  mag_x, mag_y;
    logic [31:0] c;

    assign m_dat = m_dat_drv;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    control_mouse #(
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (2)
    ) dut (
        .Clk       (clk),
        .Rst       (rst),
        .M_CLK     (m_clk),
        .M_Dat     (m_dat),
        .Click     (click),
        .Izquierda (iz),
        .Derecha   (de),
        .Arriba    (ar),
        .Abajo     (ab),
        .MagX      (mag_x),
        .MagY      (mag_y),
        .c         (c)
    );

    function automatic exp_t cur_out();
        return '{click, iz, de, ar, ab, mag_x, mag_y};
    endfunction

    function automatic exp_t mk(logic cl, logic l, logic r, logic u, logic d,
                                logic [7:0] mx, logic [7:0] my);
        return '{cl, l, r, u, d, mx, my};
    endfunction

    task automatic check_out(string name, exp_t got, exp_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got click=%b l=%b r=%b u=%b d=%b mx=%0d my=%0d, want click=%b l=%b r=%b u=%b d=%b mx=%0d my=%0d",
                     name, got.click, got.iz, got.de, got.ar, got.ab, got.mx, got.my,
                     want.click, want.iz, want.de, want.ar, want.ab, want.mx, want.my);
        end
    endtask

    task automatic check_c(string name, logic [31:0] want);
        total++;
        if (c !== want) begin
            bad++;
            $display("FAIL %s: c=%0d want %0d", name, c, want);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] frame(logic [7:0] b, logic flip);
        return {1'b1, (~^b) ^ flip, b, 1'b0};
    endfunction

    function automatic logic [32:0] pkt(logic [7:0] s, logic [7:0] x, logic [7:0] y, logic flip_x);
        return {frame(y, 1'b0), frame(x, flip_x), frame(s, 1'b0)};
    endfunction

    task automatic send_bit(logic b);
        m_dat_drv = b;
        tick(HALF);
        m_clk = 1'b0;
        tick(HALF);
        m_clk = 1'b1;
    endtask

    task automatic send_bits(logic [32:0] v, int n);
        for (int i = 0; i < n; i++) send_bit(v[i]);
        m_dat_drv = 1'b1;
    endtask

    // Expected result is queued before the packet so the monitor can pop it
    // as soon as the DUT finishes the packet.
    task automatic send_pkt(logic [7:0] s, logic [7:0] x, logic [7:0] y, logic flip_x, exp_t e);
        sb_q.push_back(e);
        send_bits(pkt(s, x, y, flip_x), 33);
        tick(40);
    endtask

    // Monitor: c must count up by one; each fall of c to zero (packet done,
    // discarded, timed out or reset) is followed by a settled output check.
    initial begin
        logic [31:0] c_prev;
        int          dly;
        exp_t        e;
        c_prev = 0;
        dly    = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (dly > 0) begin
                    dly--;
                    if (dly == 0) begin
                        if (sb_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL sb_unexpected: packet end with empty queue, c_prev=%0d", c_prev);
                        end else begin
                            e = sb_q.pop_front();
                            check_out("sb_pkt", cur_out(), e);
                        end
                    end
                end
                if (c != c_prev) begin
                    if (c == 0) begin
                        dly = 2;
                    end else begin
                        total++;
                        if (c != c_prev + 1) begin
                            bad++;
                            $display("FAIL c_step: c=%0d after %0d", c, c_prev);
                        end
                    end
                end
            end
            c_prev = c;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, queue=%0d", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t last;
        tick(5);
        rst = 1'b0;
        tick(10);
        check_out("reset_out", cur_out(), '0);
        check_c("reset_c", 32'd0);
        mon_en = 1'b1;

        send_pkt(8'h09, 8'h05, 8'h00, 1'b0, mk(1, 0, 1, 0, 0, 8'd5, 8'd0));
        send_pkt(8'h38, 8'hFB, 8'hFE, 1'b0, mk(0, 1, 0, 0, 1, 8'd5, 8'd2));
        last = mk(0, 1, 0, 0, 0, 8'd255, 8'd0);
        send_pkt(8'h18, 8'h00, 8'h00, 1'b0, last);
        // Status without the always-one bit is rejected.
        send_pkt(8'h10, 8'h00, 8'h00, 1'b0, last);
        send_pkt(8'h48, 8'h10, 8'h01, 1'b0, mk(0, 0, 1, 1, 0, 8'd255, 8'd1));
        last = mk(1, 0, 1, 1, 0, 8'd127, 8'd128);
        send_pkt(8'h0B, 8'h7F, 8'h80, 1'b0, last);
        send_pkt(8'h09, 8'h05, 8'h00, 1'b1, last);
        check_c("bad_parity_c", 32'd0);

        // Partial packet, then line idle: timeout discards it.
        sb_q.push_back(last);
        send_bits(pkt(8'h08, 8'h00, 8'h03, 1'b0), 15);
        tick(TMO - 100);
        check_c("pre_timeout_c", 32'd15);
        tick(200);
        check_c("post_timeout_c", 32'd0);
        send_pkt(8'h08, 8'h00, 8'h03, 1'b0, mk(0, 0, 0, 1, 0, 8'd0, 8'd3));

        // Reset during bit 20 clears everything.
        sb_q.push_back('0);
        send_bits(pkt(8'h09, 8'h05, 8'h00, 1'b0), 19);
        m_dat_drv = 1'b0;
        tick(HALF);
        m_clk = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        m_clk = 1'b1;
        m_dat_drv = 1'b1;
        tick(10);
        check_c("reset_mid_c", 32'd0);
        check_out("reset_mid_out", cur_out(), '0);

        send_pkt(8'h09, 8'h05, 8'h00, 1'b0, mk(1, 0, 1, 0, 0, 8'd5, 8'd0));

        tick(20);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d expected packets never seen, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
